schematic_window: RTL
=====================

// Module: schematic_window
// PURPOSE
//  Upstream feeder for the gears stage. Takes the raw schematic byte stream and
//  buffers two rows. For every character position it emits a vertical 3-cell
//  column: the row above, the centre row and the row below. Out-of-grid cells are
//  padded, so gears only shifts columns. It also learns the row width from the
//  first line and flags malformed input.
// PARAMETERS
//  MAX_WIDTH  160    max characters per row (line-buffer depth)
//  COL_W      8      width of column index / width counter; 2**COL_W > MAX_WIDTH
//  ROW_W      8      width of row index
//  PAD        8'h2E  byte substituted for out-of-grid cells ('.')
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_value   in   8      schematic byte (ASCII); 8'h0A = end of row
//  in_valid   in   1      in_value valid; accepted when in_valid & in_ready
//  in_last    in   1      marks final byte of the file; qualified by accept
//  in_ready   out  1      high in WIDTH/STREAM; low in FLUSH/DONE
//  out_valid  out  1      window column valid (1 cycle per column)
//  out_top    out  8      cell (row-1, col), PAD if row==0
//  out_mid    out  8      cell (row,   col)
//  out_bot    out  8      cell (row+1, col), PAD on last row
//  out_col    out  COL_W  column of the centre cell
//  out_row    out  ROW_W  row of the centre cell
//  out_eol    out  1      out_col == width-1 (qualified by out_valid)
//  out_done   out  1      1-cycle pulse after the last column of the last row
//  width      out  COL_W  learned row width, valid once out of WIDTH
//  err        out  1      sticky: empty first row, width>MAX_WIDTH, or ragged row
// BEHAVIOUR
//  Reset: state=WIDTH; all out_* =0; in_ready=1; width=0; err=0; counters=0.
//   Buffer contents are not cleared and are never read before they are written.
//  Registered outputs: out_* appear 1 cycle after the accept that produces them.
//  WIDTH: store bytes at buf1[col] and increment col.
//   '\n' -> width<=col, col<=0, go to STREAM. No output.
//   '\n' at col 0 -> err=1, go to DONE (pulse out_done).
//   in_last without '\n' -> width<=col+1, go to FLUSH.
//  STREAM: accept byte b at col c of input row r+1.
//   Emit top = (r==0 ? PAD : buf0[c]), mid = buf1[c], bot = b, out_row = r.
//   Then buf0[c]<=buf1[c], buf1[c]<=b.
//   '\n' is never emitted or stored. It requires c==width, else err=1 (row still
//   closes). It then resets col and increments r.
//  FLUSH: entered on in_last. If in_last is on a non-'\n' byte, that byte is
//   processed first. If the row is short, err=1; pad the missing cells with PAD.
//   Emit width columns of the final row, one per cycle: top=buf0 (PAD if r==0),
//   mid=buf1, bot=PAD. Then go to DONE.
//  DONE: out_done pulses once on entry. in_ready=0 until reset.
//  Overflow: bytes at col>=MAX_WIDTH set err and are dropped (no write, no emit).
//   Counting continues so width stays consistent.
//  Wrap: row counter wraps modulo 2**ROW_W with no error.
//  in_valid low: no state change, out_valid=0 next cycle.
//  Simultaneous in_last and '\n': treated as '\n', then FLUSH.
//  Reset mid-stream: returns to WIDTH same edge; any partial output is discarded.
// STRUCTURE
//  Package schem_pkg: NL=8'h0A, DOT=8'h2E, state enum {WIDTH,STREAM,FLUSH,DONE},
//   and the is_digit/is_symbol helper functions shared with gears.
//  Sub-module schem_line_buffer: two MAX_WIDTH x 8 arrays (buf0/buf1) with
//   combinational read at one address and a write port for each array.
//  Top: FSM, col/row counters, width register, output registers.
// TESTING
//  1. "467\n.*.\n..5\n": 9 outs. First out top=2E mid='4' bot='.' row0 col0.
//     Last out top='.' mid='5' bot=2E row2 col2, eol=1. out_done after.
//  2. Single row "12*" with in_last on '*': in_ready=0 for 3 FLUSH cycles.
//     3 outs with top=bot=2E, width=3.
//  3. Ragged "ab\ncde\n": err=1. Row 0 still emits 2 columns; no hang.
//  4. No trailing newline "ab\ncd"(last on 'd'): 4 outs. Row1 bot=2E. done=1 once.
//  5. Reset asserted mid row 2 of test 1, then replay: output matches test 1 exactly.
//  6. in_valid gapped 1-in-3 on test 1: identical out sequence, out_valid only on accepts.

Source files
------------

// File: rtl/schem_pkg.sv
// Shared definitions for the schematic front end (window feeder and gears stage).
// Holds the control byte values, the feeder state encoding and character class helpers.
package schem_pkg;

  localparam logic [7:0] NL  = 8'h0A;
  localparam logic [7:0] DOT = 8'h2E;

  typedef enum logic [1:0] {
    StWidth,
    StStream,
    StFlush,
    StDone
  } state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Anything that is not a digit, blank cell or row terminator counts as a symbol.
  function automatic logic is_symbol(input logic [7:0] c);
    return !is_digit(c) && (c != DOT) && (c != NL);
  endfunction

endpackage

// File: rtl/schem_line_buffer.sv
// Two-row line buffer for the schematic window.
// buf0 holds the row above the centre row, buf1 holds the centre row.
// Ports:
//   clk      clock, rising edge
//   addr     column address shared by both reads and both writes
//   rd0/rd1  combinational read data of buf0/buf1 at addr
//   we0/wd0  write enable/data for buf0
//   we1/wd1  write enable/data for buf1
// Contents are never cleared; the controller only reads cells it has written.
module schem_line_buffer
  import schem_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 160,
  parameter int unsigned COL_W     = 8
) (
  input  logic             clk,
  input  logic [COL_W-1:0] addr,
  output logic [7:0]       rd0,
  output logic [7:0]       rd1,
  input  logic             we0,
  input  logic [7:0]       wd0,
  input  logic             we1,
  input  logic [7:0]       wd1
);

  logic [7:0] buf0 [MAX_WIDTH];
  logic [7:0] buf1 [MAX_WIDTH];

  assign rd0 = buf0[addr];
  assign rd1 = buf1[addr];

  always_ff @(posedge clk) begin
    if (we0) buf0[addr] <= wd0;
    if (we1) buf1[addr] <= wd1;
  end

endmodule

// File: rtl/schematic_window.sv
// Schematic window feeder: turns the raw schematic byte stream into vertical
// 3-cell columns (above / centre / below) for the gears stage, padding cells
// outside the grid. Learns the row width from the first line and flags
// malformed input.
// Ports:
//   clk, reset                clock and synchronous active-high reset
//   in_value/in_valid/in_last byte stream; accepted when in_valid & in_ready
//   in_ready                  high while learning the width or streaming
//   out_valid                 one column per cycle
//   out_top/out_mid/out_bot   cells at (row-1, col), (row, col), (row+1, col)
//   out_col/out_row/out_eol   position of the centre cell, last-column flag
//   out_done                  one-cycle pulse after the final column
//   width, err                learned row width, sticky malformed-input flag
module schematic_window
  import schem_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 160,
  parameter int unsigned COL_W     = 8,
  parameter int unsigned ROW_W     = 8,
  parameter logic [7:0]  PAD       = DOT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_value,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_top,
  output logic [7:0]       out_mid,
  output logic [7:0]       out_bot,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             out_eol,
  output logic             out_done,
  output logic [COL_W-1:0] width,
  output logic             err
);

  localparam logic [COL_W-1:0] MaxCol = COL_W'(MAX_WIDTH);
  localparam logic [COL_W-1:0] ColOne = COL_W'(1);
  localparam logic [ROW_W-1:0] RowOne = ROW_W'(1);

  state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, width_q, width_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic err_q, err_d;
  logic fill_q, fill_d;  // flush is still padding out a short final row
  logic in_done_q;
  logic out_valid_q, out_valid_d, out_eol_q, out_eol_d, out_done_q, out_done_d;
  logic [7:0] out_top_q, out_top_d, out_mid_q, out_mid_d, out_bot_q, out_bot_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;

  logic [7:0] rd0, rd1, lb_wd1, emit_bot, top_cell;
  logic lb_we0, lb_we1, emit, accept, is_nl, in_range, at_last;
  logic [COL_W-1:0] col_inc;

  schem_line_buffer #(
    .MAX_WIDTH(MAX_WIDTH),
    .COL_W    (COL_W)
  ) u_line_buffer (
    .clk (clk),
    .addr(col_q),
    .rd0 (rd0),
    .rd1 (rd1),
    .we0 (lb_we0),
    .wd0 (rd1),
    .we1 (lb_we1),
    .wd1 (lb_wd1)
  );

  assign in_ready = (state_q == StWidth) || (state_q == StStream);
  assign accept   = in_valid && in_ready;
  assign is_nl    = (in_value == NL);
  assign in_range = (col_q < MaxCol);
  assign at_last  = (col_q == width_q - ColOne);
  assign col_inc  = col_q + ColOne;
  assign top_cell = (row_q == '0) ? PAD : rd0;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    width_d     = width_q;
    err_d       = err_q;
    fill_d      = fill_q;
    lb_we0      = 1'b0;
    lb_we1      = 1'b0;
    lb_wd1      = in_value;
    emit        = 1'b0;
    emit_bot    = in_value;
    out_valid_d = 1'b0;
    out_top_d   = out_top_q;
    out_mid_d   = out_mid_q;
    out_bot_d   = out_bot_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    out_eol_d   = out_eol_q;
    out_done_d  = (state_q == StDone) && !in_done_q;

    unique case (state_q)
      StWidth: begin
        if (accept) begin
          if (is_nl) begin
            if (col_q == '0) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              width_d = col_q;
              col_d   = '0;
              fill_d  = 1'b0;
              state_d = in_last ? StFlush : StStream;
            end
          end else begin
            if (in_range) lb_we1 = 1'b1;
            else          err_d  = 1'b1;
            col_d = col_inc;
            if (in_last) begin
              width_d = col_inc;
              col_d   = '0;
              fill_d  = 1'b0;
              state_d = StFlush;
            end
          end
        end
      end
      StStream: begin
        if (accept) begin
          if (is_nl) begin
            if (col_q != width_q) err_d = 1'b1;
            col_d = '0;
            row_d = row_q + RowOne;
            if (in_last) begin
              fill_d  = 1'b0;
              state_d = StFlush;
            end
          end else begin
            // Cells past the learned width have no partner above; drop them.
            if (in_range && (col_q < width_q)) begin
              emit   = 1'b1;
              lb_we0 = 1'b1;
              lb_we1 = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            col_d = col_inc;
            if (in_last) begin
              state_d = StFlush;
              if (col_inc < width_q) begin
                err_d  = 1'b1;
                fill_d = 1'b1;
              end else begin
                fill_d = 1'b0;
                col_d  = '0;
                row_d  = row_q + RowOne;
              end
            end
          end
        end
      end
      StFlush: begin
        if (fill_q) begin
          // Complete the short final row with PAD as if those bytes had arrived.
          emit_bot = PAD;
          lb_wd1   = PAD;
          if (in_range) begin
            emit   = 1'b1;
            lb_we0 = 1'b1;
            lb_we1 = 1'b1;
          end
          if (at_last) begin
            col_d  = '0;
            row_d  = row_q + RowOne;
            fill_d = 1'b0;
          end else begin
            col_d = col_inc;
          end
        end else begin
          emit_bot = PAD;
          emit     = in_range;
          if (at_last) state_d = StDone;
          else         col_d   = col_inc;
        end
      end
      StDone: ;
      default: state_d = StWidth;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_top_d   = top_cell;
      out_mid_d   = rd1;
      out_bot_d   = emit_bot;
      out_col_d   = col_q;
      out_row_d   = row_q;
      out_eol_d   = at_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StWidth;
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      err_q       <= 1'b0;
      fill_q      <= 1'b0;
      in_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_top_q   <= '0;
      out_mid_q   <= '0;
      out_bot_q   <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_eol_q   <= 1'b0;
      out_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      width_q     <= width_d;
      err_q       <= err_d;
      fill_q      <= fill_d;
      in_done_q   <= (state_q == StDone);
      out_valid_q <= out_valid_d;
      out_top_q   <= out_top_d;
      out_mid_q   <= out_mid_d;
      out_bot_q   <= out_bot_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      out_eol_q   <= out_eol_d;
      out_done_q  <= out_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_top   = out_top_q;
  assign out_mid   = out_mid_q;
  assign out_bot   = out_bot_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;
  assign out_eol   = out_eol_q;
  assign out_done  = out_done_q;
  assign width     = width_q;
  assign err       = err_q;

endmodule
